song_sequencer: RTL and testbench
=================================

# song_sequencer

Playback controller for the song note ROM (`songData`). Drives the ROM index at a fixed tempo, captures each note, and presents it to the lane/scroll logic as a one-cycle `note_valid` strobe. Owns play/pause/stop/restart sequencing and end-of-song detection. Sits between the game-control FSM (buttons) and the note display and scoring path.

## Interface
- `SONG_LEN`, 94: number of ROM entries played per pass (indices 0..SONG_LEN-1); legal range 2..128.
- `TICKS_PER_NOTE`, 12_500_000: `clk` cycles per note step; legal range ≥2.
- `CNT_W`, 24: tick counter width; must hold TICKS_PER_NOTE-1.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  begin playback from index 0; honoured in IDLE and DONE only.
- `pause`  in  1  level; while high in PLAY/PAUSE, playback is frozen.
- `stop`  in  1  abort to IDLE from any state.
- `rom_addr`  out  7  note ROM index; connects to ROM `go`.
- `rom_data`  in  5  ROM registered output; one-hot lane mask, 0 = rest.
- `note`  out  5  last captured note.
- `note_valid`  out  1  one-cycle pulse when `note` updates.
- `playing`  out  1  high in PLAY.
- `song_done`  out  1  high in DONE.
- `loop_count`  out  4  completed passes; see Configuration.

## Operation
- States: IDLE, PLAY, PAUSE, DONE. Reset value: IDLE.
- Priority, highest first: `reset` > `stop` > `pause` > `start` > tick step.
- IDLE: `rom_addr`=0, tick=0. `start` → PLAY, tick=0.
- PLAY: tick +1 per cycle. At tick==TICKS_PER_NOTE-1 a step occurs: tick←0, `note`←`rom_data`, `note_valid`←1, `rom_addr`←`rom_addr`+1.
- Step at `rom_addr`==SONG_LEN-1 (last note): emit note, `rom_addr`←0, state→DONE (or loop; see Configuration).
- `pause`=1 in PLAY → PAUSE. Tick and address are held. `pause`=0 → PLAY, and counting resumes from the held tick.
- `pause` on the same cycle as a would-be step: pause wins and no step occurs. The step fires on the first PLAY cycle after resume.
- DONE: `rom_addr`=0. `start` → PLAY from index 0, and `song_done` drops.
- `stop` in any state: → IDLE. `rom_addr`, tick and `note` are cleared to 0. No `note_valid` on that edge. `loop_count` is cleared.
- `start` in PLAY/PAUSE: ignored. `start`+`stop` together: stop wins.
- Rest entries (5'b00000) are emitted like any other note, with `note_valid`=1.

## Timing
- Reset values: `rom_addr`=0, `note`=0, `note_valid`=0, `playing`=0, `song_done`=0, `loop_count`=0.
- `rom_addr` is registered and changes only on a step, a stop, or end-of-song. It is stable for ≥TICKS_PER_NOTE-1 ≥1 cycles before each step. This covers the ROM's 1-cycle read latency, so `rom_data` equals notes[`rom_addr`] at every step edge.
- First `note_valid` occurs TICKS_PER_NOTE cycles after the edge that samples `start`. After that, one pulse every TICKS_PER_NOTE cycles in PLAY.
- `playing`/`song_done` are decoded from registered state and are valid on the cycle after the transition edge.
- `note_valid` is never high for two consecutive cycles.

## Configuration
- `SONG_LOOP_EN` defined: the last-note step sets `rom_addr`←0 and stays in PLAY. `loop_count` increments, saturating at 15. DONE is unreachable and `song_done` stays 0.
- `SONG_LOOP_EN` undefined: the last-note step → DONE. `loop_count` is tied to 0.

## Test plan
Bench uses TICKS_PER_NOTE=4 and SONG_LEN=94. The ROM model is registered, with index 0=5'b00001, 1=5'b00001, 2=5'b00100, and 93=5'b00000.
- Reset, then pulse `start` → `note_valid` at cycles 4, 8, 12 after start with `note`=00001, 00001, 00100; `rom_addr` reads 1, 2, 3 after each pulse.
- Assert `pause` for 10 cycles, starting on the cycle a step would occur → no pulse while paused; next pulse 1 cycle after `pause` drops; `rom_addr` unchanged during the pause.
- Play the full song (loop off) → exactly 94 pulses; the last has `note`=00000; `song_done`=1; `rom_addr`=0. A further `start` restarts with `note`=00001 4 cycles later.
- Pulse `stop` mid-song at `rom_addr`=37 → IDLE next cycle; `rom_addr`=0, `note`=0, no pulse. `start`+`stop` in the same cycle → stays IDLE.
- Assert `reset` asynchronously between clock edges during PLAY → all outputs reach their reset values immediately, with no clock edge needed.
- With `SONG_LOOP_EN`: play 3 passes → `loop_count`=3, `song_done`=0; pulse 95 has `note`=00001.

Source files
------------

// File: rtl/song_sequencer_if.sv
// +----------------------------------------------------------------------+
// | song_sequencer_if : control and ROM bus of the song sequencer        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface song_sequencer_if;
  logic       start;
  logic       pause;
  logic       stop;
  logic [6:0] rom_addr;
  logic [4:0] rom_data;
  logic [4:0] note;
  logic       note_valid;
  logic       playing;
  logic       song_done;
  logic [3:0] loop_count;

  // master: game control plus note ROM; slave: the sequencer itself
  modport master (
    output start, pause, stop, rom_data,
    input  rom_addr, note, note_valid, playing, song_done, loop_count
  );

  modport slave (
    input  start, pause, stop, rom_data,
    output rom_addr, note, note_valid, playing, song_done, loop_count
  );
endinterface

`default_nettype wire

// File: rtl/song_sequencer.sv
// +----------------------------------------------------------------------+
// | song_sequencer : tempo-driven note ROM playback with play/pause/stop  |
// | Optional macro SONG_LOOP_EN: wrap to index 0 and count passes.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module song_sequencer #(
  parameter int SONG_LEN       = 94,
  parameter int TICKS_PER_NOTE = 12_500_000,
  parameter int CNT_W          = 24
) (
  input  wire logic         clk,
  input  wire logic         reset,
  song_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_TICK_LAST = CNT_W'(TICKS_PER_NOTE - 1);
  localparam logic [6:0]       c_ADDR_LAST = 7'(SONG_LEN - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_tick;
  logic [6:0]       r_addr;
  logic [4:0]       r_note;
  logic             r_note_valid;
`ifdef SONG_LOOP_EN
  logic [3:0]       r_loops;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_tick       <= '0;
      r_addr       <= '0;
      r_note       <= '0;
      r_note_valid <= 1'b0;
`ifdef SONG_LOOP_EN
      r_loops      <= '0;
`endif
    end else begin
      r_note_valid <= 1'b0;
      if (bus.stop) begin
        r_state <= IDLE;
        r_tick  <= '0;
        r_addr  <= '0;
        r_note  <= '0;
`ifdef SONG_LOOP_EN
        r_loops <= '0;
`endif
      end else begin
        case (r_state)
          IDLE: begin
            r_addr <= '0;
            r_tick <= '0;
            if (bus.start) r_state <= PLAY;
          end
          PLAY: begin
            // pause outranks a step landing on the same edge; tick is held
            if (bus.pause) begin
              r_state <= PAUSE;
            end else if (r_tick == c_TICK_LAST) begin
              r_tick       <= '0;
              r_note       <= bus.rom_data;
              r_note_valid <= 1'b1;
              if (r_addr == c_ADDR_LAST) begin
                r_addr <= '0;
`ifdef SONG_LOOP_EN
                if (r_loops != 4'd15) r_loops <= r_loops + 4'd1;
`else
                r_state <= DONE;
`endif
              end else begin
                r_addr <= r_addr + 7'd1;
              end
            end else begin
              r_tick <= r_tick + CNT_W'(1);
            end
          end
          PAUSE: begin
            if (!bus.pause) r_state <= PLAY;
          end
          DONE: begin
            r_addr <= '0;
            if (bus.start) begin
              r_state <= PLAY;
              r_tick  <= '0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.rom_addr   = r_addr;
  assign bus.note       = r_note;
  assign bus.note_valid = r_note_valid;
  assign bus.playing    = (r_state == PLAY);
  assign bus.song_done  = (r_state == DONE);
`ifdef SONG_LOOP_EN
  assign bus.loop_count = r_loops;
`else
  assign bus.loop_count = 4'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_song_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_song_sequencer : scoreboard bench with a behavioural playback model|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_song_sequencer;
  localparam int LEN = 94;
  localparam int TPN = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  song_sequencer_if sif ();

  song_sequencer #(.SONG_LEN(LEN), .TICKS_PER_NOTE(TPN), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.slave)
  );

  logic [4:0] notes [0:127];
  always @(posedge clk) sif.rom_data <= notes[sif.rom_addr];

  typedef struct packed {
    logic       nv;
    logic [4:0] note;
    logic [6:0] addr;
    logic       playing;
    logic       done;
    logic [3:0] loops;
  } stat_t;
  typedef struct packed {
    logic [4:0] note;
    logic [6:0] addr;
  } pulse_t;

  stat_t  sq[$];
  pulse_t pq[$];
  int tests = 0;
  int fails = 0;
  int exp_pulses = 0;
  int got_pulses = 0;

  // model: 0 idle, 1 play, 2 pause, 3 done; phase = cycles spent on current note
  int m_state, m_phase, m_idx, m_loops;
  logic [4:0] m_note;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_phase = 0; m_idx = 0; m_loops = 0; m_note = 5'd0;
  endtask

  task automatic step(input logic st, input logic pa, input logic sp);
    logic  nv;
    stat_t s;
    @(negedge clk);
    sif.start = st; sif.pause = pa; sif.stop = sp;
    nv = 1'b0;
    if (sp) begin
      model_reset();
    end else if (m_state == 0 || m_state == 3) begin
      if (st) begin m_state = 1; m_phase = 0; end
    end else if (m_state == 2) begin
      if (!pa) m_state = 1;
    end else if (pa) begin
      m_state = 2;
    end else if (m_phase == TPN - 1) begin
      nv = 1'b1;
      m_note = notes[m_idx];
      m_phase = 0;
      if (m_idx == LEN - 1) begin
        m_idx = 0;
`ifdef SONG_LOOP_EN
        m_loops = (m_loops < 15) ? m_loops + 1 : 15;
`else
        m_state = 3;
`endif
      end else begin
        m_idx = m_idx + 1;
      end
    end else begin
      m_phase = m_phase + 1;
    end
    s.nv = nv; s.note = m_note; s.addr = 7'(m_idx);
    s.playing = (m_state == 1); s.done = (m_state == 3); s.loops = 4'(m_loops);
    sq.push_back(s);
    if (nv) begin
      pq.push_back({m_note, 7'(m_idx)});
      exp_pulses++;
    end
  endtask

  // monitor: per-cycle status plus pulse-triggered note scoreboard
  initial begin
    stat_t  s;
    pulse_t p;
    logic   prev_nv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (sq.size() > 0) begin
        s = sq.pop_front();
        check("note_valid", int'(sif.note_valid), int'(s.nv));
        check("rom_addr", int'(sif.rom_addr), int'(s.addr));
        check("playing", int'(sif.playing), int'(s.playing));
        check("song_done", int'(sif.song_done), int'(s.done));
        check("loop_count", int'(sif.loop_count), int'(s.loops));
      end
      if (sif.note_valid) begin
        got_pulses++;
        if (prev_nv) check("nv_back_to_back", 1, 0);
        if (pq.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          p = pq.pop_front();
          check("pulse_note", int'(sif.note), int'(p.note));
          check("pulse_addr", int'(sif.rom_addr), int'(p.addr));
        end
      end
      prev_nv = sif.note_valid;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_rom_addr"}, int'(sif.rom_addr), 0);
    check({tag, "_note"}, int'(sif.note), 0);
    check({tag, "_note_valid"}, int'(sif.note_valid), 0);
    check({tag, "_playing"}, int'(sif.playing), 0);
    check({tag, "_song_done"}, int'(sif.song_done), 0);
    check({tag, "_loop_count"}, int'(sif.loop_count), 0);
  endtask

  initial begin
    logic pa;
    int   r;
    int   passes;
    sif.start = 1'b0; sif.pause = 1'b0; sif.stop = 1'b0;
    for (int i = 0; i < 128; i++) begin
      r = int'($urandom_range(0, 5));
      notes[i] = (r == 5) ? 5'd0 : 5'(1 << r);
    end
    notes[0] = 5'b00001; notes[1] = 5'b00001; notes[2] = 5'b00100; notes[93] = 5'b00000;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_values("reset");
    @(negedge clk) reset = 1'b0;

    // start, then a 10-cycle pause beginning on a would-be step cycle
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40 && !(m_state == 1 && m_idx == 3 && m_phase == TPN - 1); i++)
      step(1'b0, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b1, 1'b0);

`ifdef SONG_LOOP_EN
    passes = 3;
`else
    passes = 1;
`endif
    for (int i = 0; i < 2000 && m_state != 3 && m_loops < passes; i++)
      step(1'b0, 1'b0, 1'b0);
    check("song_end_reached", (m_state == 3 || m_loops >= passes) ? 1 : 0, 1);
    repeat (5) step(1'b0, 1'b0, 1'b0);

    // restart, stop at index 37, then start+stop together
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 400 && !(m_state == 1 && m_idx == 37); i++)
      step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b0);

    // randomized control traffic
    pa = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 14) == 0) pa = ~pa;
      step(($urandom_range(0, 29) == 0), pa, ($urandom_range(0, 399) == 0));
    end

    // asynchronous reset mid-PLAY, between clock edges
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check_reset_values("async_reset");
    sq.delete();
    pq.delete();
    exp_pulses = 0;
    got_pulses = 0;
    @(negedge clk);
    model_reset();
    @(negedge clk) reset = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    check("pulse_total", got_pulses, exp_pulses);
    check("queue_drained", sq.size() + pq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
